// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing the unified instruction/data memory between fetch and load/store.
// Data normally wins contention; fetch is forced through after FETCH_MAX_WAIT consecutive losses.
module mem_arbiter #(
    parameter int unsigned       ADDR_W         = 14,
    parameter int unsigned       PC_W           = 13,
    parameter int unsigned       INSTR_W        = 18,
    parameter int unsigned       DATA_W         = 36,
    parameter logic [ADDR_W-1:0] MEM_BASE_ADDR  = 14'h2000,
    parameter int unsigned       FETCH_MAX_WAIT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_f_req,
    input  logic [PC_W-1:0]    i_f_pc,
    output logic               o_f_gnt,
    output logic               o_f_rvalid,
    output logic [INSTR_W-1:0] o_f_instr,
    input  logic               i_d_req,
    input  logic               i_d_we,
    input  logic [ADDR_W-1:0]  i_d_addr,
    input  logic [DATA_W-1:0]  i_d_wdata,
    output logic               o_d_gnt,
    output logic               o_d_rvalid,
    output logic [DATA_W-1:0]  o_d_rdata,
    output logic               o_d_err,
    output logic               o_mem_we,
    output logic               o_mem_re,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [DATA_W-1:0]  o_mem_wdata,
    input  logic [INSTR_W-1:0] i_mem_instr,
    input  logic [DATA_W-1:0]  i_mem_data
);

    typedef enum logic [0:0] {StDataPri, StFetchPri} state_e;

    state_e             state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic               f_pend_q, d_pend_q, d_we_q, d_err_q;
    logic [INSTR_W-1:0] f_instr_q;
    logic [DATA_W-1:0]  d_rdata_q;
    logic               d_in_range;

    assign d_in_range = (i_d_addr < MEM_BASE_ADDR);

    always_comb begin
        o_f_gnt = 1'b0;
        o_d_gnt = 1'b0;
        if (!i_rst) begin
            if (i_f_req && (!i_d_req || state_q == StFetchPri)) begin
                o_f_gnt = 1'b1;
            end else if (i_d_req) begin
                o_d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        if (o_f_gnt || !i_f_req) begin
            wait_cnt_d = '0;
            if (o_f_gnt) begin
                state_d = StDataPri;
            end
        end else if (o_d_gnt) begin
            // Fetch was requesting and lost this cycle.
            wait_cnt_d = wait_cnt_q + 4'd1;
            if (wait_cnt_d == 4'(FETCH_MAX_WAIT)) begin
                state_d = StFetchPri;
            end
        end
    end

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_re    = 1'b0;
        o_mem_addr  = MEM_BASE_ADDR;
        o_mem_wdata = i_d_wdata;
        if (o_f_gnt) begin
            o_mem_addr = MEM_BASE_ADDR + ADDR_W'(i_f_pc);
        end else if (o_d_gnt && d_in_range) begin
            o_mem_addr = i_d_addr;
            o_mem_we   = i_d_we;
            o_mem_re   = !i_d_we;
        end
    end

    // Responses are masked during reset so a grant just before reset never completes.
    assign o_f_rvalid = f_pend_q && !i_rst;
    assign o_d_rvalid = d_pend_q && !i_rst;
    assign o_d_err    = o_d_rvalid && d_err_q;
    assign o_f_instr  = o_f_rvalid ? i_mem_instr : f_instr_q;

    always_comb begin
        o_d_rdata = d_rdata_q;
        if (o_d_rvalid) begin
            if (d_err_q) begin
                o_d_rdata = '0;
            end else if (!d_we_q) begin
                o_d_rdata = i_mem_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StDataPri;
            wait_cnt_q <= '0;
            f_pend_q   <= 1'b0;
            d_pend_q   <= 1'b0;
            d_we_q     <= 1'b0;
            d_err_q    <= 1'b0;
            f_instr_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            f_pend_q   <= o_f_gnt;
            d_pend_q   <= o_d_gnt;
            d_we_q     <= i_d_we;
            d_err_q    <= o_d_gnt && !d_in_range;
            f_instr_q  <= o_f_instr;
            d_rdata_q  <= o_d_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then randomized traffic against a behavioural model
// built from a loss counter and a shadow copy of memory.
module tb_mem_arbiter;

    localparam int unsigned MAX_WAIT = 4;

    logic        clk, rst;
    logic        f_req, f_gnt, f_rvalid;
    logic [12:0] f_pc;
    logic [17:0] f_instr;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [13:0] d_addr;
    logic [35:0] d_wdata, d_rdata;
    logic        mem_we, mem_re;
    logic [13:0] mem_addr;
    logic [35:0] mem_wdata;
    logic [17:0] mem_instr;
    logic [35:0] mem_data;

    mem_arbiter dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_f_req     (f_req),
        .i_f_pc      (f_pc),
        .o_f_gnt     (f_gnt),
        .o_f_rvalid  (f_rvalid),
        .o_f_instr   (f_instr),
        .i_d_req     (d_req),
        .i_d_we      (d_we),
        .i_d_addr    (d_addr),
        .i_d_wdata   (d_wdata),
        .o_d_gnt     (d_gnt),
        .o_d_rvalid  (d_rvalid),
        .o_d_rdata   (d_rdata),
        .o_d_err     (d_err),
        .o_mem_we    (mem_we),
        .o_mem_re    (mem_re),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_instr (mem_instr),
        .i_mem_data  (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [35:0] init_pat(input logic [13:0] a);
        return {a[7:0] ^ 8'h5A, ~a, a};
    endfunction

    // Memory stand-in: synchronous read, unwritten words return a fixed pattern.
    logic [35:0] mem     [16384];
    logic        written [16384];
    logic [35:0] rword;
    assign rword = (written[mem_addr] === 1'b1) ? mem[mem_addr] : init_pat(mem_addr);

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_instr <= rword[17:0];
        if (mem_re) mem_data <= rword;
    end

    // Reference model state
    logic [35:0] shadow [16384];
    int          losses;
    logic        rsp_f, rsp_d, rsp_err;
    logic [17:0] rsp_instr;
    logic [35:0] rsp_rdata;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        losses    = 0;
        rsp_f     = 1'b0;
        rsp_d     = 1'b0;
        rsp_err   = 1'b0;
        rsp_instr = '0;
        rsp_rdata = '0;
    endtask

    task automatic step(input logic fr, input logic [12:0] pc, input logic dr, input logic we,
                        input logic [13:0] da, input logic [35:0] wd,
                        output logic fg, output logic dg);
        logic        exp_fg, exp_dg, in_rng;
        logic [13:0] exp_addr;
        @(posedge clk);
        #1;
        rst = 1'b0; f_req = fr; f_pc = pc; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
        exp_fg   = fr && (!dr || losses >= MAX_WAIT);
        exp_dg   = dr && !exp_fg;
        in_rng   = da < 14'h2000;
        exp_addr = exp_fg ? 14'h2000 + {1'b0, pc} : ((exp_dg && in_rng) ? da : 14'h2000);
        #4;
        chk("f_gnt", 64'(f_gnt), 64'(exp_fg));
        chk("d_gnt", 64'(d_gnt), 64'(exp_dg));
        chk("gnt_excl", 64'(f_gnt & d_gnt), 64'(0));
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        chk("mem_we", 64'(mem_we), 64'(exp_dg && in_rng && we));
        chk("mem_re", 64'(mem_re), 64'(exp_dg && in_rng && !we));
        if (exp_dg && in_rng && we) chk("mem_wdata", 64'(mem_wdata), 64'(wd));
        chk("f_rvalid", 64'(f_rvalid), 64'(rsp_f));
        chk("f_instr", 64'(f_instr), 64'(rsp_instr));
        chk("d_rvalid", 64'(d_rvalid), 64'(rsp_d));
        chk("d_err", 64'(d_err), 64'(rsp_err));
        chk("d_rdata", 64'(d_rdata), 64'(rsp_rdata));
        fg    = exp_fg;
        dg    = exp_dg;
        rsp_f = exp_fg;
        if (exp_fg) rsp_instr = shadow[exp_addr][17:0];
        rsp_d   = exp_dg;
        rsp_err = exp_dg && !in_rng;
        if (exp_dg) begin
            if (!in_rng) rsp_rdata = '0;
            else if (!we) rsp_rdata = shadow[da];
            else shadow[da] = wd;
        end
        if (exp_fg || !fr) losses = 0;
        else if (dr) losses++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0001; f_pc = '0;
        #4;
        chk("rst_f_gnt", 64'(f_gnt), 64'(0));
        chk("rst_d_gnt", 64'(d_gnt), 64'(0));
        chk("rst_f_rvalid", 64'(f_rvalid), 64'(0));
        chk("rst_d_rvalid", 64'(d_rvalid), 64'(0));
        chk("rst_d_err", 64'(d_err), 64'(0));
        chk("rst_mem_en", 64'({mem_we, mem_re}), 64'(0));
        clear_model();
    endtask

    initial begin
        logic        fg, dg, fr, dr, we;
        logic [12:0] pc;
        logic [13:0] da;
        logic [35:0] wd;
        int          fcount;
        for (int i = 0; i < 16384; i++) shadow[i] = init_pat(14'(i));
        rst = 1'b1; f_req = 0; f_pc = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        clear_model();
        do_reset();
        do_reset();

        // Lone fetch, then store/load round trip, then an out-of-range load
        step(1, 13'h0005, 0, 0, 14'h0, 36'h0, fg, dg);
        step(0, 13'h0, 1, 1, 14'h0010, 36'h123456789, fg, dg);
        step(0, 13'h0, 1, 0, 14'h0010, 36'h0, fg, dg);
        step(0, 13'h0, 1, 0, 14'h2004, 36'h0, fg, dg);
        step(0, 13'h0, 0, 0, 14'h0, 36'h0, fg, dg);
        step(1, 13'h1FFF, 0, 0, 14'h0, 36'h0, fg, dg);

        // Continuous contention: four data grants, then one fetch grant
        fcount = 0;
        for (int i = 0; i < 15; i++) begin
            step(1, 13'(i), 1, 0, 14'(i), 36'h0, fg, dg);
            if (fg) fcount++;
        end
        chk("contention_fetch_grants", 64'(fcount), 64'(3));

        // Back-to-back loads
        step(0, 13'h0, 1, 0, 14'h0001, 36'h0, fg, dg);
        step(0, 13'h0, 1, 0, 14'h0002, 36'h0, fg, dg);
        step(0, 13'h0, 1, 0, 14'h0003, 36'h0, fg, dg);
        step(0, 13'h0, 0, 0, 14'h0, 36'h0, fg, dg);

        // Reset while a load response is pending; arbitration must restart from data priority
        step(0, 13'h0, 1, 0, 14'h0001, 36'h0, fg, dg);
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 13'h0100, 1, 0, 14'h0040, 36'h0, fg, dg);

        // Randomized traffic honouring the hold-until-grant protocol
        fr = 0; dr = 0; pc = 0; da = 0; we = 0; wd = 0;
        for (int i = 0; i < 500; i++) begin
            if (!fr && $urandom_range(0, 99) < 60) begin
                fr = 1'b1;
                pc = 13'($urandom);
            end
            if (!dr && $urandom_range(0, 99) < 65) begin
                dr = 1'b1;
                we = 1'($urandom);
                da = ($urandom_range(0, 99) < 20) ? 14'($urandom) : 14'($urandom_range(0, 63));
                wd = 36'({$urandom(), $urandom()});
            end
            step(fr, pc, dr, we, da, wd, fg, dg);
            if (fg) fr = 1'b0;
            if (dg) dr = 1'b0;
        end
        step(0, 13'h0, 0, 0, 14'h0, 36'h0, fg, dg);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
